reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases memory, peripheral and core resets in that order after hold/init/stagger phases.
// All outputs come straight from flops (one edge after the sampled input); there is no backpressure, and sw requests outside RUN are dropped.
module reset_sequencer #(
  parameter int HOLD_CYCLES    = 5,
  parameter int STAGGER_CYCLES = 2,
  parameter int INIT_TIMEOUT   = 1024
) (
  input  logic       sys_clk,
  input  logic       ext_reset_n,
  input  logic       sw_reset_req,
  input  logic       mem_init_done,
  output logic       mem_rst_n,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       busy,
  output logic [1:0] reset_cause
);

  localparam int MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_V  = (MAX_HS > INIT_TIMEOUT) ? MAX_HS : INIT_TIMEOUT;
  localparam int CW     = ($clog2(MAX_V + 1) < 1) ? 1 : $clog2(MAX_V + 1);

  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] STAGGER_C = CW'(STAGGER_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(INIT_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_TMO = 2'b11;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_INIT,
    STAGGER,
    RUN,
    SWRST
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          mem_rst_n_q;
  logic          periph_rst_n_q;
  logic          core_rst_n_q;
  logic          busy_q;
  logic [1:0]    reset_cause_q;

  // Saturating increment: the counter can never wrap back below a threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!ext_reset_n) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      mem_rst_n_q    <= 1'b0;
      periph_rst_n_q <= 1'b0;
      core_rst_n_q   <= 1'b0;
      busy_q         <= 1'b1;
      reset_cause_q  <= CAUSE_EXT;
    end else begin
      case (state_q)
        HOLD, SWRST: begin
          if (cnt_d >= HOLD_C) begin
            mem_rst_n_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= WAIT_INIT;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        WAIT_INIT: begin
          // A same-edge init completion beats the timeout and keeps the cause.
          if (mem_init_done || (cnt_d >= TIMEOUT_C)) begin
            if (!mem_init_done) begin
              reset_cause_q <= CAUSE_TMO;
            end
            periph_rst_n_q <= 1'b1;
            cnt_q          <= '0;
            if (STAGGER_CYCLES == 0) begin
              core_rst_n_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= RUN;
            end else begin
              state_q <= STAGGER;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        STAGGER: begin
          if (cnt_d >= STAGGER_C) begin
            core_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            state_q      <= RUN;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        RUN: begin
          if (sw_reset_req) begin
            mem_rst_n_q    <= 1'b0;
            periph_rst_n_q <= 1'b0;
            core_rst_n_q   <= 1'b0;
            busy_q         <= 1'b1;
            reset_cause_q  <= CAUSE_SW;
            cnt_q          <= '0;
            state_q        <= SWRST;
          end
        end

        default: begin
          mem_rst_n_q    <= 1'b0;
          periph_rst_n_q <= 1'b0;
          core_rst_n_q   <= 1'b0;
          busy_q         <= 1'b1;
          cnt_q          <= '0;
          state_q        <= HOLD;
        end
      endcase
    end
  end

  assign mem_rst_n    = mem_rst_n_q;
  assign periph_rst_n = periph_rst_n_q;
  assign core_rst_n   = core_rst_n_q;
  assign busy         = busy_q;
  assign reset_cause  = reset_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output vectors are queued per clock edge and checked on the falling edge.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       sys_clk = 1'b0;
  logic       ext_reset_n;
  logic       sw_reset_req;
  logic       mem_init_done;
  logic       mem_rst_n;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       busy;
  logic [1:0] reset_cause;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int         cyc;
    logic [5:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  reset_sequencer #(
    .HOLD_CYCLES   (5),
    .STAGGER_CYCLES(2),
    .INIT_TIMEOUT  (16)
  ) dut (
    .sys_clk      (sys_clk),
    .ext_reset_n  (ext_reset_n),
    .sw_reset_req (sw_reset_req),
    .mem_init_done(mem_init_done),
    .mem_rst_n    (mem_rst_n),
    .periph_rst_n (periph_rst_n),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .reset_cause  (reset_cause)
  );

  always #1000 sys_clk = ~sys_clk;

  always @(posedge sys_clk) edge_n++;

  // Vector layout: {mem, periph, core, busy, cause[1:0]}
  always @(negedge sys_clk) begin
    logic [5:0] act;
    act = {mem_rst_n, periph_rst_n, core_rst_n, busy, reset_cause};
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == edge_n) begin
        checks++;
        assert (act === exp_q[i].v)
          else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", exp_q[i].tag, edge_n, act, exp_q[i].v);
          end
        exp_q.delete(i);
      end
    end
  end

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge sys_clk);
  endtask

  task automatic push_vec(input int e, input string tag, input logic m, input logic p,
                          input logic c, input logic b, input logic [1:0] cause);
    exp_t x;
    x.cyc = e;
    x.v   = {m, p, c, b, cause};
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic push_rst(input int e, input logic [1:0] cause, input string tag);
    push_vec(e, tag, 1'b0, 1'b0, 1'b0, 1'b1, cause);
  endtask

  // z: last edge with all resets forced; d: edges from mem release to periph release.
  task automatic push_seq(input int z, input int d, input logic [1:0] c0, input bit tmo,
                          input string tag);
    logic       m, p, c;
    logic [1:0] cz;
    for (int e = z + 1; e <= z + d + 8; e++) begin
      m  = (e >= z + 5);
      p  = (e >= z + 5 + d);
      c  = (e >= z + 7 + d);
      cz = (tmo && p) ? 2'b11 : c0;
      push_vec(e, tag, m, p, c, !c, cz);
    end
  endtask

  task automatic drain(input int e, input string tag);
    wait_to(e);
    checks++;
    assert (exp_q.size() == 0)
      else begin
        failures++;
        $error("FAIL %s_drain edge=%0d pending=%0d expected=0", tag, edge_n, exp_q.size());
        exp_q.delete();
      end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog edge=%0d expected run to complete", edge_n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x, y;

    // Power-on: reset low for 5 edges, init tied high.
    ext_reset_n   = 1'b0;
    sw_reset_req  = 1'b0;
    mem_init_done = 1'b1;
    for (int e = 1; e <= 5; e++) push_rst(e, 2'b01, "por_hold");
    push_seq(5, 1, 2'b01, 1'b0, "por");
    wait_to(5);
    ext_reset_n = 1'b1;
    drain(15, "por");

    // Software reset pulse in RUN; a second pulse during SWRST must be ignored.
    x = edge_n + 1;
    push_rst(x, 2'b10, "sw_take");
    push_seq(x, 1, 2'b10, 1'b0, "sw");
    sw_reset_req = 1'b1;
    wait_to(x);
    sw_reset_req = 1'b0;
    wait_to(x + 2);
    sw_reset_req = 1'b1;
    wait_to(x + 3);
    sw_reset_req = 1'b0;
    drain(x + 10, "sw");

    // Delayed init: done arrives 7 edges after mem release, then drops in RUN.
    x = edge_n + 1;
    push_rst(x, 2'b01, "dly_rst");
    push_seq(x, 7, 2'b01, 1'b0, "dly");
    ext_reset_n   = 1'b0;
    mem_init_done = 1'b0;
    wait_to(x);
    ext_reset_n = 1'b1;
    wait_to(x + 11);
    mem_init_done = 1'b1;
    wait_to(x + 14);
    mem_init_done = 1'b0;
    drain(x + 16, "dly");

    // Init timeout: done held low throughout.
    x = edge_n + 1;
    push_rst(x, 2'b01, "tmo_rst");
    push_seq(x, 16, 2'b01, 1'b1, "tmo");
    ext_reset_n = 1'b0;
    wait_to(x);
    ext_reset_n = 1'b1;
    drain(x + 25, "tmo");

    // External reset pulse mid WAIT_INIT restarts the full hold.
    x = edge_n + 1;
    push_rst(x, 2'b01, "mid_rst");
    for (int e = x + 1; e <= x + 7; e++) push_vec(e, "mid_pre", (e >= x + 5), 1'b0, 1'b0, 1'b1, 2'b01);
    ext_reset_n = 1'b0;
    wait_to(x);
    ext_reset_n = 1'b1;
    wait_to(x + 7);
    y = x + 8;
    push_rst(y, 2'b01, "mid_drop");
    push_seq(y, 1, 2'b01, 1'b0, "mid");
    ext_reset_n = 1'b0;
    wait_to(y);
    ext_reset_n   = 1'b1;
    mem_init_done = 1'b1;
    drain(y + 10, "mid");

    // External reset and software request on the same edge: external wins.
    x = edge_n + 1;
    push_rst(x, 2'b01, "simul_rst");
    push_seq(x, 1, 2'b01, 1'b0, "simul");
    ext_reset_n  = 1'b0;
    sw_reset_req = 1'b1;
    wait_to(x);
    ext_reset_n  = 1'b1;
    sw_reset_req = 1'b0;
    drain(x + 10, "simul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
